// File: rtl/serial_adder.sv
// Bit-serial adder: streams two WIDTH-bit operands LSB-first through one full-adder slice.
// Define SERIAL_ADDER_SUB_EN to enable subtract mode via the sub input.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] acc_next;

  // Single full-adder slice on the current LSBs and the looped carry
  assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign acc_next = {s_bit, acc[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in to one
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : ci;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign c_load     = ci;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          acc   <= acc_next;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          // Final bit: the result register is now aligned, publish it
          if (last_bit) begin
            sum   <= acc_next;
            co    <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level behavioural model plus directed and random stimulus.
// Honours SERIAL_ADDER_SUB_EN the same way as the design.
module tb_serial_adder;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of one operation: {co,sum}
  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
    if (SUB_EN && s) return {(x >= y), W'(x - y)};
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // Model: an accepted op is busy for W+1 cycles, with done and the new result in the last one
  logic       m_active;
  int         m_phase;
  logic [W:0] m_pend;
  logic [W:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_phase  <= 0;
      m_pend   <= '0;
      m_res    <= '0;
    end else if (m_active) begin
      if (m_phase == W + 1) begin
        m_active <= 1'b0;
      end else begin
        m_phase <= m_phase + 1;
        if (m_phase == W) m_res <= m_pend;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_phase  <= 1;
      m_pend   <= ref_result(a, b, ci, sub);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_active && (m_phase == W + 1)));
      check("result", 32'({co, sum}), 32'(m_res));
    end
  end

  // Starts one op and waits (bounded) for done; pins latency and a literal result
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic xs, input logic [W:0] lit, input string name);
    int lat;
    @(negedge clk);
    #1;
    a = xa; b = xb; ci = xc; sub = xs; start = 1'b1;
    lat = -1;
    for (int n = 1; n <= 3 * W; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(W + 1));
    check({name, "_dut"}, 32'({co, sum}), 32'(lit));
    check({name, "_model"}, 32'(m_res), 32'(lit));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'({co, sum}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, "zero");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "ripple");
    run_op(8'h5A, 8'hA5, 1'b1, 1'b0, 9'h100, "carry_in");
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, "back2back");

    // Extra start pulses mid-RUN and in the DONE cycle must be ignored
    @(negedge clk);
    #1;
    a = 8'h01; b = 8'h01; ci = 1'b0; sub = 1'b0; start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("busy_prot_result", 32'({co, sum}), 32'h002);
      end
      #1;
      start = (n == 4 || n == 9);
      if (start) a = 8'hFF;
    end
    check("busy_prot_dones", 32'(dones), 32'd1);

    // Reset four cycles into RUN clears everything and discards the op
    @(negedge clk);
    #1;
    a = 8'h77; b = 8'h11; start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'({co, sum}), 32'd0);
    dones = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    #1 rst_n = 1'b1;
    for (int n = 0; n < W + 2; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 9'h007, "after_rst");

    if (SUB_EN) begin
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, "sub_pos");
      run_op(8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF, "sub_neg");
    end

    // Random traffic: random start, operands and occasional reset; the model tracks all of it
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      #1;
      start = (($urandom % 4) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      ci    = 1'($urandom);
      sub   = 1'($urandom);
      rst_n = (($urandom % 120) != 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
